// File: rtl/lr_pkg.sv
// rtl/lr_pkg.sv - shared types and constants for the LR message-memory sequencer
package lr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WAIT,
    ST_CAP,
    ST_WR
  } lr_state_e;

  localparam int CNU_CTL_W   = 7;
  localparam int CNU_CTL_ROW = 0;
  localparam int CNU_CTL_P01 = 1;
  localparam int CNU_CTL_P23 = 2;
  localparam int CNU_CTL_P45 = 3;
  localparam int CNU_CTL_GO  = 4;
  localparam int CNU_CTL_CAP = 5;
  localparam int CNU_CTL_WR2 = 6;

  localparam int D_WID     = 6;
  localparam int LR_WORD_W = 4*D_WID + 20;

endpackage

// File: rtl/lr_seq_ctrl_addr_gen.sv
// rtl/lr_seq_ctrl_addr_gen.sv - row base register plus phase offset forming the LR memory address
module lr_addr_gen #(
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr,
  input  logic              inc,
  input  logic [1:0]        offset,
  output logic [ADDR_W-1:0] addr
);

  logic [ADDR_W-1:0] base_q, base_d;

  always_comb begin
    base_d = base_q;
    if (clr)
      base_d = '0;
    else if (inc)
      base_d = base_q + ADDR_W'(3);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      base_q <= '0;
    else
      base_q <= base_d;
  end

  assign addr = base_q + ADDR_W'(offset);

endmodule

// File: rtl/lr_seq_ctrl.sv
// rtl/lr_seq_ctrl.sv - row/iteration sequencer driving CNU strobes and LR memory accesses
// Optional LR_EARLY_STOP_EN: parity_ok at the last write of the final row ends decoding early.
module lr_seq_ctrl
  import lr_pkg::*;
#(
  parameter int N_ROW    = 36,
  parameter int ITER_MAX = 20,
  parameter int CNU_LAT  = 4,
  parameter int ADDR_W   = 7
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              parity_ok,
  output logic              busy,
  output logic              done,
  output logic [6:0]        cnu_ctl,
  output logic              iter_0,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [4:0]        iter_cnt,
  output logic [5:0]        row_cnt
);

  localparam int PH_W = $clog2(CNU_LAT) + 1;

  lr_state_e         state_q, state_d;
  logic [PH_W-1:0]   ph_q, ph_d;
  logic [5:0]        row_q, row_d;
  logic [4:0]        iter_q, iter_d;
  logic              fin_q, fin_d;
  logic              busy_q, busy_d, done_q, done_d, iter_0_q, iter_0_d;
  logic              mem_re_q, mem_re_d, mem_we_q, mem_we_d;
  logic [6:0]        cnu_q, cnu_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d, addr;
  logic [4:0]        iter_cnt_q, iter_cnt_d;
  logic [5:0]        row_cnt_q, row_cnt_d;
  logic              clr, inc, last_row, stop;

  lr_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (clr),
    .inc    (inc),
    .offset (ph_q[1:0]),
    .addr   (addr)
  );

  assign last_row = (row_q == 6'(N_ROW - 1));
`ifdef LR_EARLY_STOP_EN
  assign stop = (iter_q == 5'(ITER_MAX - 1)) || parity_ok;
`else
  logic unused_parity_ok;
  assign unused_parity_ok = parity_ok;
  assign stop = (iter_q == 5'(ITER_MAX - 1));
`endif

  // Outputs are registered from the current state, so each phase appears one cycle after its state.
  always_comb begin
    state_d    = state_q;
    ph_d       = ph_q;
    row_d      = row_q;
    iter_d     = iter_q;
    fin_d      = 1'b0;
    clr        = 1'b0;
    inc        = 1'b0;
    busy_d     = (state_q != ST_IDLE);
    done_d     = fin_q;
    iter_0_d   = (state_q != ST_IDLE) && (iter_q == 5'd0);
    cnu_d      = '0;
    mem_addr_d = mem_addr_q;
    mem_re_d   = 1'b0;
    mem_we_d   = 1'b0;
    iter_cnt_d = iter_q;
    row_cnt_d  = row_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RD;
          ph_d    = '0;
          row_d   = '0;
          iter_d  = '0;
          clr     = 1'b1;
        end
      end
      ST_RD: begin
        mem_addr_d = addr;
        mem_re_d   = (iter_q != 5'd0);
        if (ph_q == PH_W'(0)) cnu_d[CNU_CTL_ROW] = 1'b1;
        if (ph_q == PH_W'(1)) cnu_d[CNU_CTL_P01] = 1'b1;
        if (ph_q == PH_W'(2)) cnu_d[CNU_CTL_P23] = 1'b1;
        if (ph_q == PH_W'(2)) begin
          state_d = ST_WAIT;
          ph_d    = '0;
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      ST_WAIT: begin
        if (ph_q == PH_W'(0)) cnu_d[CNU_CTL_P45] = 1'b1;
        if (ph_q == PH_W'(1)) cnu_d[CNU_CTL_GO]  = 1'b1;
        if (ph_q == PH_W'(CNU_LAT - 1)) begin
          state_d = ST_CAP;
          ph_d    = '0;
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      ST_CAP: begin
        cnu_d[CNU_CTL_CAP] = 1'b1;
        state_d            = ST_WR;
        ph_d               = '0;
      end
      ST_WR: begin
        mem_we_d   = 1'b1;
        mem_addr_d = addr;
        if (ph_q == PH_W'(0)) cnu_d[CNU_CTL_WR2] = 1'b1;
        if (ph_q == PH_W'(2)) begin
          ph_d = '0;
          if (last_row && stop) begin
            state_d = ST_IDLE;
            fin_d   = 1'b1;
          end else if (last_row) begin
            state_d = ST_RD;
            row_d   = '0;
            iter_d  = iter_q + 5'd1;
            clr     = 1'b1;
          end else begin
            state_d = ST_RD;
            row_d   = row_q + 6'd1;
            inc     = 1'b1;
          end
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      ph_q       <= '0;
      row_q      <= '0;
      iter_q     <= '0;
      fin_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      iter_0_q   <= 1'b0;
      cnu_q      <= '0;
      mem_addr_q <= '0;
      mem_re_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      iter_cnt_q <= '0;
      row_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      ph_q       <= ph_d;
      row_q      <= row_d;
      iter_q     <= iter_d;
      fin_q      <= fin_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      iter_0_q   <= iter_0_d;
      cnu_q      <= cnu_d;
      mem_addr_q <= mem_addr_d;
      mem_re_q   <= mem_re_d;
      mem_we_q   <= mem_we_d;
      iter_cnt_q <= iter_cnt_d;
      row_cnt_q  <= row_cnt_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign iter_0   = iter_0_q;
  assign cnu_ctl  = cnu_q;
  assign mem_addr = mem_addr_q;
  assign mem_re   = mem_re_q;
  assign mem_we   = mem_we_q;
  assign iter_cnt = iter_cnt_q;
  assign row_cnt  = row_cnt_q;

endmodule
